// File: rtl/seq_comp_gen.sv
// Sequential magnitude comparator: compares two N-bit operands MSB-first, K bits per
// cycle, with optional two's-complement mode and early exit on the first differing digit.
`timescale 1ns/1ps
module seq_comp_gen #(
    parameter int N = 32,
    parameter int K = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_A,
    input  logic         load_B,
    input  logic [N-1:0] parallel_in_A,
    input  logic [N-1:0] parallel_in_B,
    input  logic         start,
    input  logic         signed_mode,
    output logic         busy,
    output logic         done,
    output logic         L,
    output logic         E,
    output logic         G,
    output logic [1:0]   dbg_state
);

    localparam int DIGITS = N / K;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    // Handshake: start is accepted on a rising edge only while not busy (IDLE or DONE);
    // busy stays high until the deciding edge, which also raises done for exactly one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d;
    logic [N-1:0]  sa_q, sa_d, sb_q, sb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          l_q, l_d, e_q, e_d, g_q, g_d;
    logic [K-1:0]  dig_a, dig_b;

    always_comb begin
        dig_a = sa_q[N-1 -: K];
        dig_b = sb_q[N-1 -: K];
        // Flipping the sign bit of the leading digit turns a signed compare into an unsigned one.
        if (cnt_q == '0 && mode_q) begin
            dig_a[K-1] = ~dig_a[K-1];
            dig_b[K-1] = ~dig_b[K-1];
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        l_d     = l_q;
        e_d     = e_q;
        g_d     = g_q;
        case (state_q)
            IDLE, DONE: begin
                if (load_A) a_d = parallel_in_A;
                if (load_B) b_d = parallel_in_B;
                if (start) begin
                    sa_d    = load_A ? parallel_in_A : a_q;
                    sb_d    = load_B ? parallel_in_B : b_q;
                    mode_d  = signed_mode;
                    cnt_d   = '0;
                    l_d     = 1'b0;
                    e_d     = 1'b0;
                    g_d     = 1'b0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (dig_a > dig_b) begin
                    g_d     = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (dig_a < dig_b) begin
                    l_d     = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == LAST) begin
                    e_d     = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    sa_d  = sa_q << K;
                    sb_d  = sb_q << K;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            g_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            l_q     <= l_d;
            e_q     <= e_d;
            g_q     <= g_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign L         = l_q;
    assign E         = e_q;
    assign G         = g_q;
    assign dbg_state = state_q;

endmodule
